control_sequencer: RTL and testbench

//  Registered, multi-cycle successor to the single-cycle control decoder. Decodes the

---
 rtl/ctrl_pkg.sv | 43 ++++
 rtl/control_decode.sv | 30 +++
 rtl/control_sequencer.sv | 149 ++++++++++++++
 tb/tb_control_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the control sequencer: opcode map, FSM states and the
// datapath control bundle.
package ctrl_pkg;

  localparam int unsigned OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ALUI  = 4'b0000,
    OP_BEQ   = 4'b0001,
    OP_BNE   = 4'b0010,
    OP_BLT   = 4'b0011,
    OP_LOAD  = 4'b0100,
    OP_STORE = 4'b0101,
    OP_PUSH  = 4'b0110,
    OP_RTYPE = 4'b0111,
    OP_ALU8  = 4'b1000,
    OP_ALU9  = 4'b1001,
    OP_ALU10 = 4'b1010,
    OP_ALU11 = 4'b1011,
    OP_ALU12 = 4'b1100,
    OP_ALU13 = 4'b1101,
    OP_NOP   = 4'b1110,
    OP_HALT  = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2,
    HALT    = 2'd3
  } state_e;

  typedef struct packed {
    logic    regdst;
    logic    branch;
    logic    memtoreg;
    logic    memwrite;
    logic    alusrc;
    logic    regwrite;
    opcode_e aluop;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Pure combinational opcode decode into the datapath control bundle.
module control_decode
  import ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl
);

  always_comb begin
    ctrl          = '0;
    ctrl.regwrite = 1'b1;
    ctrl.aluop    = opcode_e'(opcode);
    case (opcode_e'(opcode))
      OP_ALUI: ctrl.alusrc = 1'b1;
      OP_BEQ, OP_BNE, OP_BLT: begin
        ctrl.branch   = 1'b1;
        ctrl.regwrite = 1'b0;
      end
      OP_LOAD: ctrl.memtoreg = 1'b1;
      OP_STORE: begin
        ctrl.memwrite = 1'b1;
        ctrl.regwrite = 1'b0;
      end
      OP_RTYPE: ctrl.regdst = 1'b1;
      OP_NOP, OP_HALT: ctrl.regwrite = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Registered multi-cycle control sequencer: decodes opcodes into the control
// bundle one cycle later, stretches loads over the memory latency, halts and counts.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned MCODEBITS = 4,
  parameter int unsigned OPWIDTH   = 4,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned CNTW      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MCODEBITS-1:0] instr,
  input  logic                 instr_valid,
  output logic                 RegDst,
  output logic                 Branch,
  output logic                 MemtoReg,
  output logic                 MemWrite,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic [OPWIDTH-1:0]   ALUOp,
  output logic                 pc_en,
  output logic                 stall,
  output logic                 done,
  output logic [CNTW-1:0]      cycle_cnt,
  output logic [CNTW-1:0]      instr_cnt
);

  localparam int unsigned WAITW = $clog2(MEM_LAT + 1);

  state_e              state_q, state_d;
  ctrl_t               ctrl_q, ctrl_d, dec_ctrl;
  logic                pc_en_q, pc_en_d;
  logic                stall_q, stall_d;
  logic                done_q, done_d;
  logic [WAITW-1:0]    wait_q, wait_d;
  logic [CNTW-1:0]     cycle_q, cycle_d;
  logic [CNTW-1:0]     icnt_q, icnt_d;
  logic [OPCODE_W-1:0] opcode;

  assign opcode = instr[MCODEBITS-1 -: OPCODE_W];

  control_decode u_decode (
    .opcode (opcode),
    .ctrl   (dec_ctrl)
  );

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  // Next state, next registered outputs and counter updates
  always_comb begin
    state_d = state_q;
    ctrl_d  = '0;
    pc_en_d = 1'b0;
    stall_d = 1'b0;
    done_d  = done_q;
    wait_d  = wait_q;
    cycle_d = cycle_q;
    icnt_d  = icnt_q;

    if (state_q == RUN || state_q == MEMWAIT) cycle_d = sat_inc(cycle_q);

    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          done_d  = 1'b0;
          cycle_d = '0;
          icnt_d  = '0;
        end
      end
      RUN: begin
        if (instr_valid) begin
          ctrl_d  = dec_ctrl;
          pc_en_d = 1'b1;
          case (opcode_e'(opcode))
            OP_LOAD: begin
              ctrl_d.regwrite = 1'b0;
              pc_en_d         = 1'b0;
              stall_d         = 1'b1;
              wait_d          = WAITW'(MEM_LAT);
              state_d         = MEMWAIT;
            end
            OP_HALT: begin
              pc_en_d = 1'b0;
              done_d  = 1'b1;
              state_d = HALT;
            end
            default: ;
          endcase
        end
      end
      MEMWAIT: begin
        // Hold the load bundle; write back and retire on the last wait cycle
        ctrl_d = ctrl_q;
        if (wait_q == WAITW'(1)) begin
          ctrl_d.regwrite = 1'b1;
          pc_en_d         = 1'b1;
          state_d         = RUN;
        end else begin
          stall_d = 1'b1;
          wait_d  = wait_q - WAITW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (pc_en_d) icnt_d = sat_inc(icnt_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      pc_en_q <= 1'b0;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
      wait_q  <= '0;
      cycle_q <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      pc_en_q <= pc_en_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      wait_q  <= wait_d;
      cycle_q <= cycle_d;
      icnt_q  <= icnt_d;
    end
  end

  assign RegDst    = ctrl_q.regdst;
  assign Branch    = ctrl_q.branch;
  assign MemtoReg  = ctrl_q.memtoreg;
  assign MemWrite  = ctrl_q.memwrite;
  assign ALUSrc    = ctrl_q.alusrc;
  assign RegWrite  = ctrl_q.regwrite;
  assign ALUOp     = OPWIDTH'(ctrl_q.aluop);
  assign pc_en     = pc_en_q;
  assign stall     = stall_q;
  assign done      = done_q;
  assign cycle_cnt = cycle_q;
  assign instr_cnt = icnt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a 16-bit-counter instance and a
// 4-bit-counter instance share stimulus; counter saturation is checked on the latter.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, instr_valid;
  logic [3:0] instr;

  logic        rd, br, mr, mw, as, rw, pc, st, dn;
  logic [3:0]  op;
  logic [15:0] ccnt, icnt;
  logic        rd4, br4, mr4, mw4, as4, rw4, pc4, st4, dn4;
  logic [3:0]  op4;
  logic [3:0]  ccnt4, icnt4;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  control_sequencer #(.MCODEBITS(4), .OPWIDTH(4), .MEM_LAT(2), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .instr_valid(instr_valid),
    .RegDst(rd), .Branch(br), .MemtoReg(mr), .MemWrite(mw), .ALUSrc(as), .RegWrite(rw),
    .ALUOp(op), .pc_en(pc), .stall(st), .done(dn), .cycle_cnt(ccnt), .instr_cnt(icnt)
  );

  control_sequencer #(.MCODEBITS(4), .OPWIDTH(4), .MEM_LAT(2), .CNTW(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .instr_valid(instr_valid),
    .RegDst(rd4), .Branch(br4), .MemtoReg(mr4), .MemWrite(mw4), .ALUSrc(as4), .RegWrite(rw4),
    .ALUOp(op4), .pc_en(pc4), .stall(st4), .done(dn4), .cycle_cnt(ccnt4), .instr_cnt(icnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected vector layout: {RegDst,Branch,MemtoReg,MemWrite,ALUSrc,RegWrite}_{ALUOp}_{pc_en,stall,done}
  task automatic chk_ctl(input string tag, input logic [12:0] exp);
    chk({tag, "/ctl16"}, 32'({rd, br, mr, mw, as, rw, op, pc, st, dn}), 32'(exp));
    chk({tag, "/ctl4"}, 32'({rd4, br4, mr4, mw4, as4, rw4, op4, pc4, st4, dn4}), 32'(exp));
  endtask

  task automatic chk_cnt(input string tag, input int c16, input int i16, input int c4, input int i4);
    chk({tag, "/cycle16"}, 32'(ccnt), 32'(c16));
    chk({tag, "/instr16"}, 32'(icnt), 32'(i16));
    chk({tag, "/cycle4"}, 32'(ccnt4), 32'(c4));
    chk({tag, "/instr4"}, 32'(icnt4), 32'(i4));
  endtask

  initial begin
    int ci, cc;
    reset = 1'b1; start = 1'b0; instr = 4'b0000; instr_valid = 1'b0;
    tick(); tick();
    chk_ctl("reset", 13'b000000_0000_000);
    chk_cnt("reset", 0, 0, 0, 0);
    reset = 1'b0;

    start = 1'b1;
    tick();
    chk_ctl("start", 13'b000000_0000_000);
    chk_cnt("start", 0, 0, 0, 0);
    start = 1'b0;

    instr = 4'b1000; instr_valid = 1'b1;
    tick();
    chk_ctl("alu8", 13'b000001_1000_100);
    chk_cnt("alu8", 1, 1, 1, 1);

    instr = 4'b0100;
    tick();
    chk_ctl("load1", 13'b001000_0100_010);
    instr = 4'b1000;
    tick();
    chk_ctl("load2", 13'b001000_0100_010);
    instr = 4'b0010;
    tick();
    chk_ctl("load3", 13'b001001_0100_100);
    chk_cnt("load3", 4, 2, 4, 2);

    tick();
    chk_ctl("branch", 13'b010000_0010_100);
    instr = 4'b0101;
    tick();
    chk_ctl("store", 13'b000100_0101_100);
    instr = 4'b1110;
    tick();
    chk_ctl("nop", 13'b000000_1110_100);
    chk_cnt("nop", 7, 5, 7, 5);

    instr_valid = 1'b0;
    tick();
    chk_ctl("bubble", 13'b000000_0000_000);
    chk_cnt("bubble", 8, 5, 8, 5);

    instr = 4'b0000; instr_valid = 1'b1;
    tick();
    chk_ctl("alui", 13'b000011_0000_100);
    instr = 4'b0111;
    tick();
    chk_ctl("rtype", 13'b100001_0111_100);
    instr = 4'b0110; start = 1'b1;
    tick();
    chk_ctl("push_start_ignored", 13'b000001_0110_100);
    chk_cnt("push_start_ignored", 11, 8, 11, 8);
    start = 1'b0;

    instr = 4'b1111;
    tick();
    chk_ctl("halt", 13'b000000_1111_001);
    chk_cnt("halt", 12, 8, 12, 8);
    instr = 4'b1000;
    tick();
    chk_ctl("halted1", 13'b000000_0000_001);
    tick();
    chk_ctl("halted2", 13'b000000_0000_001);
    chk_cnt("halted2", 12, 8, 12, 8);

    start = 1'b1;
    tick();
    chk_ctl("restart", 13'b000000_0000_000);
    chk_cnt("restart", 0, 0, 0, 0);
    start = 1'b0;
    tick();
    chk_ctl("restart_alu", 13'b000001_1000_100);
    chk_cnt("restart_alu", 1, 1, 1, 1);

    // Reset in the middle of a load aborts it without a write
    instr = 4'b0100;
    tick();
    chk_ctl("load_pre_reset", 13'b001000_0100_010);
    reset = 1'b1; start = 1'b1;
    tick();
    chk_ctl("reset_mid1", 13'b000000_0000_000);
    chk_cnt("reset_mid1", 0, 0, 0, 0);
    tick(); tick();
    chk_ctl("reset_mid3", 13'b000000_0000_000);
    chk_cnt("reset_mid3", 0, 0, 0, 0);
    reset = 1'b0; start = 1'b0;
    tick();
    chk_ctl("idle_ignores", 13'b000000_0000_000);
    chk_cnt("idle_ignores", 0, 0, 0, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk_cnt("sat_start", 0, 0, 0, 0);

    ci = 0; cc = 0;
    instr = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      if (i == 5 || i == 10 || i == 15) begin
        instr_valid = 1'b0;
        tick();
        cc++;
        chk_ctl("sat_bubble", 13'b000000_0000_000);
      end
      instr_valid = 1'b1;
      tick();
      cc++; ci++;
      chk_ctl("sat_alu", 13'b000001_1000_100);
      if (i == 14) chk_cnt("sat_at15", cc, ci, 15, 15);
    end
    chk_cnt("sat_final", 23, 20, 15, 15);
    instr_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
